// File: rtl/game_reaction_if.sv
// Signal bundle between the game controller and the games top level.
// The top level (master) drives the controls; the game (slave) drives the display.
interface game_reaction_if;
   logic       ena;
   logic       btn_pulse;
   logic [3:0] rand_digit;
   logic [3:0] disp_val;
   logic       disp_blank;
   logic       disp_dp;
   logic       go_led;
   logic [2:0] state_o;

   modport master (
      output ena, btn_pulse, rand_digit,
      input  disp_val, disp_blank, disp_dp, go_led, state_o
   );

   modport slave (
      input  ena, btn_pulse, rand_digit,
      output disp_val, disp_blank, disp_dp, go_led, state_o
   );
endinterface

// File: rtl/game_reaction.sv
// Reaction-time game: arm, random delay, GO, measure press latency in ticks,
// then show the result and keep the best score across rounds.
module game_reaction #(
   parameter int TICK_CYCLES     = 1000000,
   parameter int DELAY_MIN_TICKS = 10,
   parameter int TIMEOUT_TICKS   = 10
) (
   input logic            clk,
   input logic            rst_n,
   game_reaction_if.slave bus
);

   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
   localparam logic [7:0]    DELAY_MIN = 8'(DELAY_MIN_TICKS);
   localparam logic [3:0]    TO_LAST   = 4'(TIMEOUT_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT   = 3'd1,
      S_GO     = 3'd2,
      S_RESULT = 3'd3,
      S_FOUL   = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [PW-1:0] r_presc;
   logic [7:0]    r_delay;
   logic [3:0]    r_react;
   logic [3:0]    r_result;
   logic [3:0]    r_best;
   logic          r_new_best;
   logic          w_tick;
   logic          w_trans;
   logic [3:0]    w_rand_clamp;
   logic [3:0]    w_result;

   assign w_tick       = (r_presc == TICK_LAST);
   assign w_trans      = (w_state_nxt != r_state);
   assign w_rand_clamp = (bus.rand_digit > 4'd9) ? 4'd9 : bus.rand_digit;
   // A press scores the pre-increment count; reaching the timeout scores 9.
   assign w_result     = bus.btn_pulse ? ((r_react > 4'd9) ? 4'd9 : r_react) : 4'd9;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decision; a press in WAIT beats the expiring tick
   always_comb begin
      w_state_nxt = r_state;
      if (!bus.ena) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.btn_pulse) w_state_nxt = S_WAIT;
               else               w_state_nxt = S_IDLE;
            end
            S_WAIT: begin
               if (bus.btn_pulse)                     w_state_nxt = S_FOUL;
               else if (w_tick && r_delay == 8'd1)    w_state_nxt = S_GO;
               else                                   w_state_nxt = S_WAIT;
            end
            S_GO: begin
               if (bus.btn_pulse)                     w_state_nxt = S_RESULT;
               else if (w_tick && r_react == TO_LAST) w_state_nxt = S_RESULT;
               else                                   w_state_nxt = S_GO;
            end
            S_RESULT, S_FOUL: begin
               if (bus.btn_pulse) w_state_nxt = S_IDLE;
               else               w_state_nxt = r_state;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Tick prescaler, delay and reaction counters, result and best score
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc    <= '0;
         r_delay    <= 8'd0;
         r_react    <= 4'd0;
         r_result   <= 4'd0;
         r_best     <= 4'd9;
         r_new_best <= 1'b0;
      end else if (!bus.ena) begin
         r_presc <= '0;
         r_delay <= 8'd0;
         r_react <= 4'd0;
      end else begin
         if (w_trans || w_tick) r_presc <= '0;
         else                   r_presc <= r_presc + 1'b1;

         if (r_state == S_IDLE && w_state_nxt == S_WAIT)
            r_delay <= DELAY_MIN + {4'd0, w_rand_clamp};
         else if (r_state == S_WAIT && w_tick && r_delay != 8'd0)
            r_delay <= r_delay - 8'd1;

         if (r_state != S_GO && w_state_nxt == S_GO)
            r_react <= 4'd0;
         else if (r_state == S_GO && w_tick && r_react != 4'hF)
            r_react <= r_react + 4'd1;

         if (r_state == S_GO && w_state_nxt == S_RESULT) begin
            r_result <= w_result;
            if (w_result < r_best) begin
               r_best     <= w_result;
               r_new_best <= 1'b1;
            end else begin
               r_new_best <= 1'b0;
            end
         end
      end
   end

   // Display decode from registered state only
   always_comb begin
      bus.disp_val   = 4'd0;
      bus.disp_blank = 1'b1;
      bus.disp_dp    = 1'b0;
      bus.go_led     = 1'b0;
      case (r_state)
         S_IDLE: begin
            bus.disp_blank = 1'b1;
            bus.disp_dp    = 1'b1;
         end
         S_WAIT: begin
            bus.disp_blank = 1'b1;
         end
         S_GO: begin
            bus.disp_blank = 1'b0;
            bus.go_led     = 1'b1;
         end
         S_RESULT: begin
            bus.disp_val   = r_result;
            bus.disp_blank = 1'b0;
            bus.disp_dp    = r_new_best;
         end
         S_FOUL: begin
            bus.disp_val   = 4'hF;
            bus.disp_blank = 1'b0;
         end
         default: begin
            bus.disp_blank = 1'b1;
         end
      endcase
   end

   assign bus.state_o = r_state;

endmodule

// File: tb/tb_game_reaction.sv
// Directed bench for game_reaction with a 4-cycle tick, 2-tick minimum delay
// and 10-tick timeout; observed word is {state, value, blank, dp, go_led}.
module tb_game_reaction;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   logic [9:0] w_obs;

   localparam logic [9:0] E_IDLE = {3'd0, 4'h0, 1'b1, 1'b1, 1'b0};
   localparam logic [9:0] E_WAIT = {3'd1, 4'h0, 1'b1, 1'b0, 1'b0};
   localparam logic [9:0] E_GO   = {3'd2, 4'h0, 1'b0, 1'b0, 1'b1};
   localparam logic [9:0] E_FOUL = {3'd4, 4'hF, 1'b0, 1'b0, 1'b0};

   game_reaction_if bus ();

   game_reaction #(
      .TICK_CYCLES     (4),
      .DELAY_MIN_TICKS (2),
      .TIMEOUT_TICKS   (10)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   assign w_obs = {bus.state_o, bus.disp_val, bus.disp_blank, bus.disp_dp, bus.go_led};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      bus.btn_pulse = 1'b1;
      @(posedge clk);
      #1;
      bus.btn_pulse = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wait_cycles(2);
      if (w_obs !== E_IDLE) begin n_err++; $display("FAIL reset: got %h exp %h", w_obs, E_IDLE); end
      n_cmp++;
      rst_n = 1'b1;
      wait_cycles(1);
   endtask

   task automatic test_round_new_best();
      bus.rand_digit = 4'd3;
      pulse();
      if (w_obs !== E_WAIT) begin n_err++; $display("FAIL arm_wait: got %h exp %h", w_obs, E_WAIT); end
      n_cmp++;
      wait_cycles(19);
      if (w_obs !== E_WAIT) begin n_err++; $display("FAIL wait_19: got %h exp %h", w_obs, E_WAIT); end
      n_cmp++;
      wait_cycles(1);
      if (w_obs !== E_GO) begin n_err++; $display("FAIL go_at_20: got %h exp %h", w_obs, E_GO); end
      n_cmp++;
      wait_cycles(8);
      pulse();
      if (w_obs !== {3'd3, 4'd2, 1'b0, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL result_2_best: got %h exp %h", w_obs, {3'd3, 4'd2, 1'b0, 1'b1, 1'b0});
      end
      n_cmp++;
      pulse();
      if (w_obs !== E_IDLE) begin n_err++; $display("FAIL result_to_idle: got %h exp %h", w_obs, E_IDLE); end
      n_cmp++;
   endtask

   task automatic test_foul();
      bus.rand_digit = 4'd0;
      pulse();
      wait_cycles(4);
      pulse();
      if (w_obs !== E_FOUL) begin n_err++; $display("FAIL foul: got %h exp %h", w_obs, E_FOUL); end
      n_cmp++;
      wait_cycles(30);
      if (w_obs !== E_FOUL) begin n_err++; $display("FAIL foul_hold: got %h exp %h", w_obs, E_FOUL); end
      n_cmp++;
      pulse();
      if (w_obs !== E_IDLE) begin n_err++; $display("FAIL foul_to_idle: got %h exp %h", w_obs, E_IDLE); end
      n_cmp++;
   endtask

   task automatic test_timeout_clamp();
      bus.rand_digit = 4'd12;
      pulse();
      wait_cycles(43);
      if (w_obs !== E_WAIT) begin n_err++; $display("FAIL clamp_wait_43: got %h exp %h", w_obs, E_WAIT); end
      n_cmp++;
      wait_cycles(1);
      if (w_obs !== E_GO) begin n_err++; $display("FAIL clamp_go_44: got %h exp %h", w_obs, E_GO); end
      n_cmp++;
      wait_cycles(39);
      if (w_obs !== E_GO) begin n_err++; $display("FAIL timeout_39: got %h exp %h", w_obs, E_GO); end
      n_cmp++;
      wait_cycles(1);
      if (w_obs !== {3'd3, 4'd9, 1'b0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL timeout_40: got %h exp %h", w_obs, {3'd3, 4'd9, 1'b0, 1'b0, 1'b0});
      end
      n_cmp++;
      pulse();
   endtask

   task automatic test_ena_abort();
      bus.rand_digit = 4'd0;
      pulse();
      wait_cycles(8);
      if (w_obs !== E_GO) begin n_err++; $display("FAIL ena_go: got %h exp %h", w_obs, E_GO); end
      n_cmp++;
      wait_cycles(2);
      bus.ena = 1'b0;
      wait_cycles(1);
      if (w_obs !== E_IDLE) begin n_err++; $display("FAIL ena_low_idle: got %h exp %h", w_obs, E_IDLE); end
      n_cmp++;
      pulse();
      if (w_obs !== E_IDLE) begin n_err++; $display("FAIL ena_low_ignore: got %h exp %h", w_obs, E_IDLE); end
      n_cmp++;
      bus.ena = 1'b1;
      wait_cycles(1);
      pulse();
      wait_cycles(8);
      wait_cycles(12);
      pulse();
      if (w_obs !== {3'd3, 4'd3, 1'b0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL best_retained: got %h exp %h", w_obs, {3'd3, 4'd3, 1'b0, 1'b0, 1'b0});
      end
      n_cmp++;
      pulse();
   endtask

   task automatic test_coincident();
      bus.rand_digit = 4'd0;
      pulse();
      wait_cycles(7);
      pulse();
      if (w_obs !== E_FOUL) begin n_err++; $display("FAIL foul_on_tick: got %h exp %h", w_obs, E_FOUL); end
      n_cmp++;
      pulse();
      pulse();
      wait_cycles(8);
      if (w_obs !== E_GO) begin n_err++; $display("FAIL coin_go: got %h exp %h", w_obs, E_GO); end
      n_cmp++;
      wait_cycles(7);
      pulse();
      if (w_obs !== {3'd3, 4'd1, 1'b0, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL press_on_tick: got %h exp %h", w_obs, {3'd3, 4'd1, 1'b0, 1'b1, 1'b0});
      end
      n_cmp++;
      pulse();
   endtask

   task automatic test_reset_mid_wait();
      bus.rand_digit = 4'd0;
      pulse();
      wait_cycles(3);
      if (w_obs !== E_WAIT) begin n_err++; $display("FAIL pre_rst_wait: got %h exp %h", w_obs, E_WAIT); end
      n_cmp++;
      rst_n = 1'b0;
      #1;
      if (w_obs !== E_IDLE) begin n_err++; $display("FAIL async_rst: got %h exp %h", w_obs, E_IDLE); end
      n_cmp++;
      #2;
      rst_n = 1'b1;
      wait_cycles(1);
      pulse();
      wait_cycles(8);
      wait_cycles(12);
      pulse();
      if (w_obs !== {3'd3, 4'd3, 1'b0, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL best_reset_9: got %h exp %h", w_obs, {3'd3, 4'd3, 1'b0, 1'b1, 1'b0});
      end
      n_cmp++;
   endtask

   initial begin
      n_cmp          = 0;
      n_err          = 0;
      rst_n          = 1'b0;
      bus.ena        = 1'b1;
      bus.btn_pulse  = 1'b0;
      bus.rand_digit = 4'd0;
      test_reset();
      test_round_new_best();
      test_foul();
      test_timeout_clamp();
      test_ena_abort();
      test_coincident();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/game_reaction.md
Name: game_reaction

Overview:
- Reaction-time game for the seven-segment games top level.
- Sits downstream of button_pulse (one-cycle press) and random_digit (pseudo-random 0–9 source).
- Sits upstream of sevenseg_driver, which decodes a 4-bit hex value, a blank flag and a decimal point.
- Game flow: arm, random delay, GO, measure press latency in 100 ms ticks, show result and track best score.

Parameters:
TICK_CYCLES, 1000000, clock cycles per game tick (100 ms at 10 MHz).
DELAY_MIN_TICKS, 10, fixed part of the pre-GO delay in ticks; legal range 1..245.
TIMEOUT_TICKS, 10, ticks in GO after which the round ends as a timeout; legal range 1..15.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  game selected; low forces IDLE
btn_pulse  in  1  single-cycle press strobe from button_pulse
rand_digit  in  4  random value from random_digit, sampled at arm time
disp_val  out  4  hex digit to sevenseg_driver
disp_blank  out  1  1 = all segments off
disp_dp  out  1  decimal point
go_led  out  1  high while in GO
state_o  out  3  current state encoding, for debug and top-level muxing

Behaviour:
- One clock. Reset is asynchronous and active-low (rst_n); all state registers clear immediately on rst_n low.
- Reset values:
  - State: IDLE.
  - best = 9, result = 0, delay_cnt = 0, react_cnt = 0, prescaler = 0.
  - Outputs: disp_blank = 1, disp_dp = 1, disp_val = 0, go_led = 0, state_o = 0.
- State encoding: IDLE = 0, WAIT = 1, GO = 2, RESULT = 3, FOUL = 4.
- Outputs are combinational decodes of registered state only. They change on the clock edge that updates the state, one cycle after the causing btn_pulse or tick.
- Prescaler:
  - Counts 0..TICK_CYCLES-1; tick = 1 for one cycle when the count equals TICK_CYCLES-1.
  - Cleared on every state transition, so the first tick after entering a state occurs exactly TICK_CYCLES cycles after entry.
- IDLE:
  - Outputs: disp_blank = 1, disp_dp = 1 (ready indicator).
  - On btn_pulse: go to WAIT and load delay_cnt = DELAY_MIN_TICKS + min(rand_digit, 9). rand_digit values 10–15 clamp to 9.
- WAIT:
  - Outputs: disp_blank = 1, disp_dp = 0.
  - On each tick, delay_cnt decrements; on the tick where delay_cnt = 1, go to GO with react_cnt = 0.
  - btn_pulse in WAIT goes to FOUL. If btn_pulse coincides with the expiring tick, FOUL wins.
- GO:
  - Outputs: go_led = 1, disp_val = 0, disp_blank = 0, disp_dp = 0.
  - On each tick, react_cnt increments.
  - On btn_pulse: result = min(react_cnt, 9) using the pre-increment value, even if a tick fires the same cycle; go to RESULT.
  - If react_cnt reaches TIMEOUT_TICKS with no press: result = 9; go to RESULT.
- RESULT:
  - On entry: if result < best, then best = result and new_best = 1; otherwise new_best = 0. new_best is a register.
  - Outputs: disp_val = result, disp_blank = 0, disp_dp = new_best.
  - On btn_pulse: go to IDLE.
- FOUL:
  - Outputs: disp_val = 4'hF, disp_blank = 0, disp_dp = 0.
  - On btn_pulse: go to IDLE.
- go_led = 0 in every state except GO.
- ena = 0: next clock forces IDLE, clears the counters and ignores btn_pulse. best is retained. Outputs show the IDLE values.
- Register widths:
  - delay_cnt: 8 bits.
  - react_cnt: 4 bits, saturating; never wraps.
  - prescaler: $clog2(TICK_CYCLES) bits.
- Asynchronous reset mid-round returns to IDLE with best = 9.
- No combinational path from btn_pulse to any output.

Test Plan:
All scenarios use TICK_CYCLES = 4, DELAY_MIN_TICKS = 2, TIMEOUT_TICKS = 10, ena = 1.
1. Reset -> disp_blank = 1, disp_dp = 1, go_led = 0, state_o = 0.
2. rand_digit = 3, pulse in IDLE -> state_o = 1 next cycle; go_led rises exactly 20 cycles after WAIT entry. Pulse 9 cycles after GO entry -> RESULT, disp_val = 2, disp_dp = 1 (new best), disp_blank = 0.
3. Pulse in WAIT 5 cycles after entry -> disp_val = F, disp_blank = 0, go_led stays 0. Next pulse -> IDLE.
4. rand_digit = 12 (clamped to 9): go_led rises 44 cycles after WAIT entry. No press -> 40 cycles after GO entry, RESULT with disp_val = 9 and disp_dp = 0, since best is already ≤ 9.
5. Pulse on the same cycle as the final WAIT tick -> FOUL, not GO. Pulse on a GO tick cycle with react_cnt = 1 -> result 1.
6. ena low during GO -> IDLE next cycle, go_led = 0, best retained (verified by a later result of 3 giving disp_dp = 0 when best = 2). rst_n low mid-WAIT -> immediate IDLE, best = 9.
